// File: rtl/ethernet_pkg.sv
// Shared types and helpers for the multi-slot AXIS Ethernet receiver.
package ethernet_pkg;

  localparam int unsigned max_keep_lp     = 64;
  localparam int unsigned keep_count_w_lp = 7;

  typedef enum logic [1:0] {
    rx_idle_s = 2'd0,
    rx_recv_s = 2'd1,
    rx_drop_s = 2'd2
  } rx_state_e;

  // One-cycle increment strobes, one per statistics cause
  typedef struct packed {
    logic good;
    logic bad;
    logic oversize;
    logic overflow;
  } stat_inc_t;

  // Byte count of a tlast beat: index of highest set keep bit plus one
  function automatic logic [keep_count_w_lp-1:0] bytes_from_tkeep(
    input logic [max_keep_lp-1:0] keep
  );
    logic [keep_count_w_lp-1:0] n;
    n = '0;
    for (int i = 0; i < int'(max_keep_lp); i++) begin
      if (keep[i]) n = keep_count_w_lp'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/ethernet_rx_slot_mem.sv
// Frame slot storage: 1R1W synchronous RAM with registered, held read data.
module ethernet_rx_slot_mem #(
  parameter int unsigned width_p      = 64,
  parameter int unsigned els_p        = 1024,
  parameter int unsigned addr_width_p = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic                    r_v_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  // Read data only changes on a read request
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data_o <= '0;
    end else if (r_v_i) begin
      r_data_o <= mem_r[r_addr_i];
    end
  end

endmodule

// File: rtl/ethernet_receiver_mslot.sv
// Multi-slot AXIS Ethernet RX buffer: MAC stream in, host-readable frame slots out in arrival order.
module ethernet_receiver_mslot
  import ethernet_pkg::*;
#(
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned eth_mtu_p        = 2048,
  parameter int unsigned slots_p          = 4,
  parameter int unsigned drop_when_full_p = 1,
  parameter int unsigned count_width_p    = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  output logic                           packet_avail_o,
  input  logic                           packet_ack_i,
  input  logic                           packet_rvalid_i,
  input  logic [$clog2(eth_mtu_p)-1:0]   packet_raddr_i,
  output logic [data_width_p-1:0]        packet_rdata_o,
  output logic [$clog2(eth_mtu_p+1)-1:0] packet_rsize_o,
  input  logic [data_width_p-1:0]        rx_axis_tdata_i,
  input  logic [data_width_p/8-1:0]      rx_axis_tkeep_i,
  input  logic                           rx_axis_tvalid_i,
  output logic                           rx_axis_tready_o,
  input  logic                           rx_axis_tlast_i,
  input  logic                           rx_axis_tuser_i,
  output logic [count_width_p-1:0]       good_count_o,
  output logic [count_width_p-1:0]       bad_count_o,
  output logic [count_width_p-1:0]       oversize_count_o,
  output logic [count_width_p-1:0]       overflow_count_o,
  output logic [$clog2(slots_p+1)-1:0]   slots_used_o
);

  localparam int unsigned bpw_lp     = data_width_p / 8;
  localparam int unsigned lg_bpw_lp  = $clog2(bpw_lp);
  localparam int unsigned words_lp   = eth_mtu_p / bpw_lp;
  localparam int unsigned word_w_lp  = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int unsigned slot_w_lp  = $clog2(slots_p);
  localparam int unsigned size_w_lp  = $clog2(eth_mtu_p + 1);
  localparam int unsigned used_w_lp  = $clog2(slots_p + 1);
  localparam int unsigned cnt_w_lp   = count_width_p;
  localparam int unsigned mem_aw_lp  = slot_w_lp + word_w_lp;
  localparam int unsigned mem_els_lp = slots_p * (1 << word_w_lp);

  rx_state_e              state_r, state_n;
  logic [word_w_lp-1:0]   ptr_r, ptr_n;
  logic                   oversize_r, oversize_n;
  logic [slot_w_lp-1:0]   head_r, head_n;
  logic [slot_w_lp-1:0]   tail_r, tail_n;
  logic [used_w_lp-1:0]   used_r, used_n;
  logic                   avail_r;
  logic                   tready_r, tready_n;
  logic [size_w_lp-1:0]   rsize_r, rsize_n;
  logic [size_w_lp-1:0]   size_r [slots_p];
  logic [cnt_w_lp-1:0]    good_r, bad_r, oversize_cnt_r, overflow_cnt_r;

  logic                       beat;
  logic                       full;
  logic                       ack_ok;
  logic                       wr_v;
  logic                       commit;
  stat_inc_t                  inc;
  logic [keep_count_w_lp-1:0] keep_bytes;
  logic [size_w_lp-1:0]       commit_size;
  logic [word_w_lp-1:0]       rd_word;

  assign beat       = rx_axis_tvalid_i & tready_r;
  assign full       = (used_r == used_w_lp'(slots_p));
  assign ack_ok     = packet_ack_i & avail_r;
  assign keep_bytes = bytes_from_tkeep(max_keep_lp'(rx_axis_tkeep_i));
  assign rd_word    = word_w_lp'(packet_raddr_i >> lg_bpw_lp);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= rx_idle_s;
    else            state_r <= state_n;
  end

  // Write FSM plus slot bookkeeping; idle with a free slot behaves like receive at word 0
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    oversize_n  = oversize_r;
    wr_v        = 1'b0;
    commit      = 1'b0;
    inc         = '0;
    commit_size = (size_w_lp'(ptr_r) << lg_bpw_lp) + size_w_lp'(keep_bytes);

    case (state_r)
      rx_idle_s, rx_recv_s: begin
        if (beat) begin
          if (state_r == rx_idle_s && full) begin
            if (rx_axis_tlast_i) begin
              inc.overflow = 1'b1;
            end else begin
              state_n    = rx_drop_s;
              oversize_n = 1'b0;
            end
          end else begin
            wr_v = 1'b1;
            if (rx_axis_tlast_i) begin
              state_n = rx_idle_s;
              ptr_n   = '0;
              if (rx_axis_tuser_i) begin
                inc.bad = 1'b1;
              end else begin
                commit   = 1'b1;
                inc.good = 1'b1;
              end
            end else if (ptr_r == word_w_lp'(words_lp - 1)) begin
              state_n    = rx_drop_s;
              ptr_n      = '0;
              oversize_n = 1'b1;
            end else begin
              state_n = rx_recv_s;
              ptr_n   = ptr_r + word_w_lp'(1);
            end
          end
        end
      end
      rx_drop_s: begin
        if (beat && rx_axis_tlast_i) begin
          state_n = rx_idle_s;
          if (oversize_r) inc.oversize = 1'b1;
          else            inc.overflow = 1'b1;
        end
      end
      default: begin
        state_n = rx_idle_s;
        ptr_n   = '0;
      end
    endcase

    used_n   = used_r + used_w_lp'(commit) - used_w_lp'(ack_ok);
    head_n   = head_r + slot_w_lp'(ack_ok);
    tail_n   = tail_r + slot_w_lp'(commit);
    tready_n = !(state_n == rx_idle_s && used_n == used_w_lp'(slots_p) &&
                 drop_when_full_p == 0);

    // Size array is written on this edge, so bypass when the new frame becomes head
    if (used_n == '0)                   rsize_n = '0;
    else if (commit && head_n == tail_r) rsize_n = commit_size;
    else                                 rsize_n = size_r[head_n];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r      <= '0;
      oversize_r <= 1'b0;
      head_r     <= '0;
      tail_r     <= '0;
      used_r     <= '0;
      avail_r    <= 1'b0;
      tready_r   <= 1'b0;
      rsize_r    <= '0;
      for (int i = 0; i < int'(slots_p); i++) size_r[i] <= '0;
    end else begin
      ptr_r      <= ptr_n;
      oversize_r <= oversize_n;
      head_r     <= head_n;
      tail_r     <= tail_n;
      used_r     <= used_n;
      avail_r    <= (used_n != '0);
      tready_r   <= tready_n;
      rsize_r    <= rsize_n;
      if (commit) size_r[tail_r] <= commit_size;
    end
  end

  // Saturating per-cause statistics
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      good_r         <= '0;
      bad_r          <= '0;
      oversize_cnt_r <= '0;
      overflow_cnt_r <= '0;
    end else begin
      if (inc.good && good_r != '1)                 good_r <= good_r + cnt_w_lp'(1);
      if (inc.bad && bad_r != '1)                   bad_r <= bad_r + cnt_w_lp'(1);
      if (inc.oversize && oversize_cnt_r != '1)     oversize_cnt_r <= oversize_cnt_r + cnt_w_lp'(1);
      if (inc.overflow && overflow_cnt_r != '1)     overflow_cnt_r <= overflow_cnt_r + cnt_w_lp'(1);
    end
  end

  ethernet_rx_slot_mem #(
    .width_p      (data_width_p),
    .els_p        (mem_els_lp),
    .addr_width_p (mem_aw_lp)
  ) slot_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .w_v_i     (wr_v),
    .w_addr_i  ({tail_r, ptr_r}),
    .w_data_i  (rx_axis_tdata_i),
    .r_v_i     (packet_rvalid_i),
    .r_addr_i  ({head_r, rd_word}),
    .r_data_o  (packet_rdata_o)
  );

  assign packet_avail_o   = avail_r;
  assign packet_rsize_o   = rsize_r;
  assign rx_axis_tready_o = tready_r;
  assign good_count_o     = good_r;
  assign bad_count_o      = bad_r;
  assign oversize_count_o = oversize_cnt_r;
  assign overflow_count_o = overflow_cnt_r;
  assign slots_used_o     = used_r;

endmodule
